mini_alu_controller: RTL and testbench

Multi-cycle sequencer for the Mini-ALU that drives one shared `six_bit_ripple_adder` instance to execute ADD, SUB, NEG and an iterative shift-add MUL on 6-bit operands. It sits between the operand source (switches/testbench) and the result/flag display logic. It accepts one operation at a time through a valid/ready handshake and holds the result and flags until the consumer accepts them.

---
 rtl/mini_alu_controller.sv | 239 +++++++++++++++++++++++
 tb/tb_mini_alu_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mini_alu_controller.sv
// Multi-cycle Mini-ALU sequencer: ADD/SUB/NEG through one shared ripple adder, MUL as iterative shift-add.
// Latency: ADD/SUB/NEG (and unsupported op) 1 cycle from accept; MUL MUL_ITERS cycles from accept.
// Backpressure: one op in flight; in_ready only in IDLE, result/flags held in DONE until out_ready.
//
// Optional feature macro: MINI_ALU_MUL_EN (defined -> MUL supported; undefined -> op 11 flags err).
//
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   in_valid/in_ready         : request handshake, op/a/b captured on accept
//   out_valid/out_ready       : result handshake
//   result, carry, overflow   : registered arithmetic outputs
//   zero, negative            : derived from registered result
//   err                       : unsupported op, busy: controller not idle

module six_bit_ripple_adder #(
    parameter int W = 6
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_sel,      // 1: x + ~y + 1 (subtract)
    output logic [W-1:0] o_sum,
    output logic         o_c_out,
    output logic         o_overflow
);
    logic [W-1:0] w_y;
    logic [W:0]   w_c;

    assign w_y    = i_y ^ {W{i_sel}};
    assign w_c[0] = i_sel;

    for (genvar k = 0; k < W; k++) begin : g_fa
        assign o_sum[k]   = i_x[k] ^ w_y[k] ^ w_c[k];
        assign w_c[k+1]   = (i_x[k] & w_y[k]) | (w_c[k] & (i_x[k] ^ w_y[k]));
    end

    assign o_c_out    = w_c[W];
    // signed overflow: carry into MSB differs from carry out of MSB
    assign o_overflow = w_c[W] ^ w_c[W-1];
endmodule

module mini_alu_controller #(
    parameter int MUL_ITERS = 6   // also the operand width
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [MUL_ITERS-1:0] a,
    input  logic [MUL_ITERS-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MUL_ITERS-1:0] result,
    output logic                 carry,
    output logic                 overflow,
    output logic                 zero,
    output logic                 negative,
    output logic                 err,
    output logic                 busy
);
    localparam int W = MUL_ITERS;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_NEG = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

`ifdef MINI_ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL_ITER, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`endif

    state_t       r_state, w_next;
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;
    logic [W-1:0] r_result;
    logic         r_carry, r_overflow, r_err;

    logic [W-1:0] w_x, w_y, w_sum;
    logic         w_sel, w_c_out, w_ovf;

`ifdef MINI_ALU_MUL_EN
    localparam int CNT_W = $clog2(MUL_ITERS + 1);
    logic [W-1:0]     r_acc, r_mcand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sticky;
    logic [W-1:0]     w_acc_nxt;
    logic             w_sticky_nxt;
    logic             w_last;
`endif

    six_bit_ripple_adder #(.W(W)) u_adder (
        .i_x        (w_x),
        .i_y        (w_y),
        .i_sel      (w_sel),
        .o_sum      (w_sum),
        .o_c_out    (w_c_out),
        .o_overflow (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next state and shared-adder operand mux
    always_comb begin
        w_next = r_state;
        w_x    = r_a;
        w_y    = r_b;
        w_sel  = 1'b0;
`ifdef MINI_ALU_MUL_EN
        w_last       = (r_cnt == CNT_W'(MUL_ITERS - 1));
        w_acc_nxt    = r_acc;
        w_sticky_nxt = r_sticky;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef MINI_ALU_MUL_EN
                    w_next = (op == OP_MUL) ? S_MUL_ITER : S_EXEC;
`else
                    w_next = S_EXEC;
`endif
                end
            end
            S_EXEC: begin
                w_next = S_DONE;
                case (r_op)
                    OP_SUB:  w_sel = 1'b1;
                    OP_NEG: begin
                        w_x   = '0;
                        w_y   = r_a;
                        w_sel = 1'b1;
                    end
                    default: w_sel = 1'b0;
                endcase
            end
`ifdef MINI_ALU_MUL_EN
            S_MUL_ITER: begin
                w_x = r_acc;
                w_y = r_mcand;
                if (r_b[r_cnt]) begin
                    w_acc_nxt    = w_sum;
                    w_sticky_nxt = w_sticky_nxt | w_c_out;
                end
                // a multiplicand bit falling off the top only matters if a later B bit would add it
                if (r_mcand[W-1] && (|(r_b >> (r_cnt + 1'b1))))
                    w_sticky_nxt = 1'b1;
                if (w_last) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op       <= OP_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
`ifdef MINI_ALU_MUL_EN
            r_acc      <= '0;
            r_mcand    <= '0;
            r_cnt      <= '0;
            r_sticky   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op <= op;
                        r_a  <= a;
                        r_b  <= b;
`ifdef MINI_ALU_MUL_EN
                        r_acc    <= '0;
                        r_mcand  <= a;
                        r_cnt    <= '0;
                        r_sticky <= 1'b0;
`endif
                    end
                end
                S_EXEC: begin
`ifdef MINI_ALU_MUL_EN
                    r_result   <= w_sum;
                    r_carry    <= w_c_out;
                    r_overflow <= w_ovf;
                    r_err      <= 1'b0;
`else
                    if (r_op == OP_MUL) begin
                        r_result   <= '0;
                        r_carry    <= 1'b0;
                        r_overflow <= 1'b0;
                        r_err      <= 1'b1;
                    end else begin
                        r_result   <= w_sum;
                        r_carry    <= w_c_out;
                        r_overflow <= w_ovf;
                        r_err      <= 1'b0;
                    end
`endif
                end
`ifdef MINI_ALU_MUL_EN
                S_MUL_ITER: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_cnt    <= r_cnt + 1'b1;
                    r_sticky <= w_sticky_nxt;
                    if (w_last) begin
                        r_result   <= w_acc_nxt;
                        r_overflow <= w_sticky_nxt;
                        r_carry    <= 1'b0;
                        r_err      <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign err       = r_err;
    assign zero      = (r_result == '0);
    assign negative  = r_result[W-1];
endmodule

// File: tb/tb_mini_alu_controller.sv
module tb_mini_alu_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] op = 2'b00;
    logic [5:0] a = '0;
    logic [5:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] result;
    logic       carry, overflow, zero, negative, err, busy;

    int n_total = 0;
    int n_fail  = 0;
    int lat;

    mini_alu_controller #(.MUL_ITERS(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // present a request for one edge, then measure edges until out_valid
    task automatic issue(input logic [1:0] o, input logic [5:0] xa, input logic [5:0] xb);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic check_out(input string tag, input int r, input int c, input int v,
                             input int z, input int n, input int e);
        chk({tag, ".result"},   int'(result),   r);
        chk({tag, ".carry"},    int'(carry),    c);
        chk({tag, ".overflow"}, int'(overflow), v);
        chk({tag, ".zero"},     int'(zero),     z);
        chk({tag, ".negative"}, int'(negative), n);
        chk({tag, ".err"},      int'(err),      e);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".idle_after_hs"}, int'(in_ready), 1);
        chk({tag, ".ovld_after_hs"}, int'(out_valid), 0);
    endtask

    initial begin
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", int'(in_ready), 1);
        chk("rst.busy", int'(busy), 0);
        chk("rst.out_valid", int'(out_valid), 0);
        check_out("rst", 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD 20+11
        issue(2'b00, 6'd20, 6'd11);
        chk("add1.latency", lat, 1);
        check_out("add1", 31, 0, 0, 0, 0, 0);
        consume("add1");
        // ADD 31+1 -> signed overflow
        issue(2'b00, 6'd31, 6'd1);
        chk("add2.latency", lat, 1);
        check_out("add2", 32, 0, 1, 0, 1, 0);
        consume("add2");

        // SUB
        issue(2'b01, 6'd5, 6'd7);
        check_out("sub1", 62, 0, 0, 0, 1, 0);
        consume("sub1");
        issue(2'b01, 6'd7, 6'd7);
        check_out("sub2", 0, 1, 0, 1, 0, 0);
        consume("sub2");

        // NEG
        issue(2'b10, 6'd32, 6'd5);
        check_out("neg1", 32, 0, 1, 0, 1, 0);
        consume("neg1");
        issue(2'b10, 6'd1, 6'd9);
        check_out("neg2", 63, 0, 0, 0, 1, 0);
        consume("neg2");

`ifdef MINI_ALU_MUL_EN
        issue(2'b11, 6'd7, 6'd9);
        chk("mul1.latency", lat, 6);
        check_out("mul1", 63, 0, 0, 0, 1, 0);
        consume("mul1");
        issue(2'b11, 6'd8, 6'd8);
        chk("mul2.latency", lat, 6);
        check_out("mul2", 0, 0, 1, 1, 0, 0);
        consume("mul2");
`else
        issue(2'b11, 6'd7, 6'd9);
        chk("mulx.latency", lat, 1);
        check_out("mulx", 0, 0, 0, 1, 0, 1);
        consume("mulx");
`endif

        // backpressure: result held 5 cycles, new request waits
        issue(2'b00, 6'd10, 6'd12);
        check_out("bp0", 22, 0, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; a = 6'd9; b = 6'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.out_valid", int'(out_valid), 1);
            chk("bp.in_ready", int'(in_ready), 0);
            chk("bp.result", int'(result), 22);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp.hs_in_ready", int'(in_ready), 1);
        chk("bp.hs_busy", int'(busy), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.accepted_busy", int'(busy), 1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk("bp2.latency", lat, 1);
        check_out("bp2", 5, 1, 0, 0, 0, 0);
        consume("bp2");

        // reset mid-operation
`ifdef MINI_ALU_MUL_EN
        @(negedge clk);
        in_valid = 1'b1; op = 2'b11; a = 6'd7; b = 6'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid.busy_before", int'(busy), 1);
`else
        issue(2'b00, 6'd3, 6'd4);
        chk("rstmid.held", int'(out_valid), 1);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstmid.in_ready", int'(in_ready), 1);
        chk("rstmid.busy", int'(busy), 0);
        chk("rstmid.out_valid", int'(out_valid), 0);
        check_out("rstmid", 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b00, 6'd2, 6'd3);
        chk("post.latency", lat, 1);
        check_out("post", 5, 0, 0, 0, 0, 0);
        consume("post");

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
